uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

UART receive engine: the receiving end of the serial link whose TX pin the transmit path drives. Samples the synchronized RX pad signal at mid-bit and deframes start/data/parity/stop using the same baud_value/EIGHT/PEN/OHEL configuration as the transmitter. Presents a received byte with RXRDY and parity/framing/overrun status to the UART's read side. Sits between the RX IBUF in the TSI and the UART register interface.

## Interface
- BIT_TIME_OVERRIDE, 0, when nonzero replaces the baud table bit time in clocks (simulation speed-up); 0 = use table
- HALF_MIN, 2, minimum half-bit count when BIT_TIME_OVERRIDE is small (guards against zero)
- clk  input  1  system clock, 100 MHz; single clock domain
- reset  input  1  asynchronous, active-low; all state cleared while low
- baud_value  input  4  baud select
- EIGHT  input  1  1 = 8 data bits, 0 = 7
- PEN  input  1  1 = parity bit present
- OHEL  input  1  parity sense: 1 = odd, 0 = even
- RX  input  1  serial line, idle high, asynchronous to clk
- read  input  1  one-cycle pulse: consumer has taken rx_data; clears RXRDY, PERR, FERR, OVF
- rx_data  output  8  received character, LSB first on the line; bit 7 = 0 in 7-bit mode
- RXRDY  output  1  character available
- PERR  output  1  parity error on latest character
- FERR  output  1  stop bit sampled low on latest character
- OVF  output  1  character completed while RXRDY still set

## Operation
- Bit time k (clocks): baud_value 0..B = 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109 (300..921600 baud); C..F = 109. Counter 19 bits. Override replaces k when nonzero. Half time = k>>1 (minimum HALF_MIN).
- RX passes a 2-flop synchronizer (reset to 1), then a 1-flop history; start edge = sync 0 with history 1.
- EIGHT, PEN, OHEL, k latched at start edge; changes mid-frame ignored.
- States: IDLE, START, SHIFT, STOP.
  - IDLE: on start edge, load counter with half time -> START.
  - START: counter expiry: line 0 -> load k, bit index 0 -> SHIFT; line 1 -> false start, IDLE, no flags touched.
  - SHIFT: each expiry samples one bit into an LSB-first shift register, reloads k. Data bits = 7 or 8, then parity bit if PEN. After last -> STOP.
  - STOP: expiry samples stop bit; update outputs; -> IDLE same cycle.
- Completion update (one cycle): rx_data loaded (bit 7 forced 0 if 7-bit); FERR = stop sample==0; PERR = PEN and XOR(data bits, parity bit) != OHEL, else 0; OVF = RXRDY already set and no read this cycle; RXRDY = 1.
- Overrun: new data overwrites rx_data; OVF stays set until read.
- read with no completion same cycle: RXRDY, PERR, FERR, OVF -> 0; rx_data held. read with completion same cycle: completion wins, OVF = 0.
- Break (line held low): FERR on that frame; a new start requires the line to return high first (edge detect).

## Timing
- Reset: rx_data=0, RXRDY=0, PERR=0, FERR=0, OVF=0, state IDLE, synchronizer=1.
- Start-edge detect 3 clocks after RX falls (2 sync + history).
- Samples at start edge + k/2 + n*k, n=0 (start) .. last (stop).
- Status outputs registered; valid the clock after the stop-bit sample; stable until next completion or read.
- Reset low mid-frame: frame discarded, outputs to reset values, IDLE after release; a line already low at release is not a start (needs edge).
- Frame length 9..11 bit times; back-to-back frames (next start right after stop) received without loss.

## Test plan
- Override 16, 8N1, send 0xA5 -> rx_data=0xA5, RXRDY=1, PERR=FERR=OVF=0 one clock after stop sample; read pulse -> RXRDY=0, rx_data still 0xA5.
- 7 data, PEN=1, OHEL=0, send 0x41 with parity bit 1 (wrong) -> rx_data=0x41, PERR=1; resend with parity 0 -> PERR=0.
- 8N1, send 0x3C with stop bit driven 0 -> FERR=1, RXRDY=1, rx_data=0x3C; hold line low -> no further frame until line returns high.
- RX low pulse of 4 clocks (less than k/2) from idle -> returns IDLE, RXRDY stays 0, no flag change.
- Two frames 0x11 then 0x22 without read -> rx_data=0x22, OVF=1; repeat with read on the completion cycle -> OVF=0, RXRDY=1.
- Assert reset low mid-data of 0xFF frame -> all outputs 0 immediately; after release, next clean 0x5A frame received correctly; baud_value=8 with no override, 0x55 -> mid-bit samples spaced 868 clocks.

Source files
------------

// File: rtl/uart_rx_engine_if.sv
// Read-side bus between the UART receive engine and the register interface.
interface uart_rx_engine_if;
    logic [7:0] rx_data;
    logic       rxrdy;
    logic       perr;
    logic       ferr;
    logic       ovf;
    logic       read;

    modport master (output rx_data, rxrdy, perr, ferr, ovf, input read);
    modport slave  (input rx_data, rxrdy, perr, ferr, ovf, output read);
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes RX, samples mid-bit, deframes start/data/parity/stop
// and presents the character with ready/parity/framing/overrun status.
module uart_rx_engine #(
    parameter int unsigned BIT_TIME_OVERRIDE = 0,
    parameter int unsigned HALF_MIN          = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        baud_value_i,
    input  logic              eight_i,
    input  logic              pen_i,
    input  logic              ohel_i,
    input  logic              rx_i,
    uart_rx_engine_if.master  rd_if
);

    localparam int unsigned CNT_W = 19;
    localparam logic [CNT_W-1:0] OVR_K      = CNT_W'(BIT_TIME_OVERRIDE);
    localparam logic [CNT_W-1:0] HALF_MIN_K = CNT_W'(HALF_MIN);

    typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_e;

    function automatic logic [CNT_W-1:0] table_k(input logic [3:0] b);
        logic [CNT_W-1:0] k;
        case (b)
            4'd0:    k = 19'd333333;
            4'd1:    k = 19'd83333;
            4'd2:    k = 19'd41667;
            4'd3:    k = 19'd20833;
            4'd4:    k = 19'd10417;
            4'd5:    k = 19'd5208;
            4'd6:    k = 19'd2604;
            4'd7:    k = 19'd1736;
            4'd8:    k = 19'd868;
            4'd9:    k = 19'd434;
            4'd10:   k = 19'd217;
            default: k = 19'd109;
        endcase
        return k;
    endfunction

    state_e           state_q;
    logic             sync1_q, sync2_q, hist_q;
    logic [1:0]       warm_q;
    logic [CNT_W-1:0] cnt_q, k_q;
    logic             eight_q, pen_q, ohel_q;
    logic [3:0]       idx_q;
    logic [8:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             rxrdy_q, perr_q, ferr_q, ovf_q;

    logic [CNT_W-1:0] k_d, half_d;
    logic             start_edge_c, expire_c, done_c, par_bit_c, perr_c;
    logic [3:0]       last_idx_c;
    logic [7:0]       data_c;

    always_comb begin
        k_d          = (BIT_TIME_OVERRIDE != 0) ? OVR_K : table_k(baud_value_i);
        half_d       = ((k_d >> 1) < HALF_MIN_K) ? HALF_MIN_K : (k_d >> 1);
        start_edge_c = hist_q & ~sync2_q;
        expire_c     = (cnt_q == 19'd1);
        last_idx_c   = (eight_q ? 4'd7 : 4'd6) + {3'b000, pen_q};
        data_c       = eight_q ? shift_q[7:0] : {1'b0, shift_q[6:0]};
        par_bit_c    = eight_q ? shift_q[8] : shift_q[7];
        perr_c       = pen_q & ((^data_c ^ par_bit_c) != ohel_q);
        done_c       = (state_q == STOP) & expire_c;
    end

    // History stays low until the synchronizer carries real line samples,
    // so a line already low at reset release cannot look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            hist_q    <= 1'b0;
            warm_q    <= 2'b00;
            cnt_q     <= '0;
            k_q       <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
            hist_q  <= warm_q[1] ? sync2_q : 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_edge_c) begin
                        cnt_q   <= half_d;
                        k_q     <= k_d;
                        eight_q <= eight_i;
                        pen_q   <= pen_i;
                        ohel_q  <= ohel_i;
                        state_q <= START;
                    end
                end
                START: begin
                    if (!expire_c) begin
                        cnt_q <= cnt_q - 19'd1;
                    end else if (!sync2_q) begin
                        cnt_q   <= k_q;
                        idx_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (!expire_c) begin
                        cnt_q <= cnt_q - 19'd1;
                    end else begin
                        shift_q[idx_q] <= sync2_q;
                        cnt_q          <= k_q;
                        if (idx_q == last_idx_c) state_q <= STOP;
                        else                     idx_q   <= idx_q + 4'd1;
                    end
                end
                STOP: begin
                    if (!expire_c) cnt_q   <= cnt_q - 19'd1;
                    else           state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // A completion outranks a read landing in the same cycle.
            if (done_c) begin
                rx_data_q <= data_c;
                ferr_q    <= ~sync2_q;
                perr_q    <= perr_c;
                ovf_q     <= rxrdy_q & ~rd_if.read;
                rxrdy_q   <= 1'b1;
            end else if (rd_if.read) begin
                rxrdy_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
        end
    end

    assign rd_if.rx_data = rx_data_q;
    assign rd_if.rxrdy   = rxrdy_q;
    assign rd_if.perr    = perr_q;
    assign rd_if.ferr    = ferr_q;
    assign rd_if.ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed scoreboard bench for uart_rx_engine: a fast instance (bit time 16)
// and a table-driven instance (baud_value 8, 868 clocks per bit).
module tb_uart_rx_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] baud_a, baud_b;
    logic       eight, pen, ohel;
    logic       rx_a, rx_b;

    always #5 clk = ~clk;

    uart_rx_engine_if if_a ();
    uart_rx_engine_if if_b ();

    uart_rx_engine #(.BIT_TIME_OVERRIDE(16), .HALF_MIN(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_value_i(baud_a), .eight_i(eight),
        .pen_i(pen), .ohel_i(ohel), .rx_i(rx_a), .rd_if(if_a)
    );

    uart_rx_engine #(.BIT_TIME_OVERRIDE(0), .HALF_MIN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_value_i(baud_b), .eight_i(eight),
        .pen_i(pen), .ohel_i(ohel), .rx_i(rx_b), .rd_if(if_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       rxrdy;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic r, input logic p, input logic f, input logic o);
        exp_t e;
        e.data = d; e.rxrdy = r; e.perr = p; e.ferr = f; e.ovf = o;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input bit sel, input string tag);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        checks--;
        e = sb_q.pop_front();
        chk({tag, ".data"},  sel ? if_b.rx_data : if_a.rx_data, e.data);
        chk({tag, ".rxrdy"}, sel ? if_b.rxrdy   : if_a.rxrdy,   e.rxrdy);
        chk({tag, ".perr"},  sel ? if_b.perr    : if_a.perr,    e.perr);
        chk({tag, ".ferr"},  sel ? if_b.ferr    : if_a.ferr,    e.ferr);
        chk({tag, ".ovf"},   sel ? if_b.ovf     : if_a.ovf,     e.ovf);
    endtask

    task automatic read_pulse(input bit sel);
        if (sel) if_b.read = 1'b1; else if_a.read = 1'b1;
        tick(1);
        if (sel) if_b.read = 1'b0; else if_a.read = 1'b0;
    endtask

    // Drives one frame slot by slot; the stop sample lands on edge ce
    // (3 edges to detect the start, then half + stop_index * k).
    task automatic send_frame(input bit sel, input int k, input int half, input logic [7:0] data,
                              input bit seven, input bit par_en, input logic par_bit,
                              input logic stop_bit, input bit rd_on_done, input int abort_at,
                              output logic pre, output logic post);
        logic bits [11];
        int   nb, ndata, ce;
        ndata   = seven ? 7 : 8;
        bits[0] = 1'b0;
        for (int i = 0; i < ndata; i++) bits[1+i] = data[i];
        nb = 1 + ndata;
        if (par_en) begin
            bits[nb] = par_bit;
            nb++;
        end
        bits[nb] = stop_bit;
        ce  = 3 + half + nb * k;
        nb++;
        pre  = 1'bx;
        post = 1'bx;
        for (int c = 0; c < nb * k; c++) begin
            if (abort_at > 0 && c == abort_at) break;
            if (sel) begin
                rx_b = bits[c / k];
                if_b.read = rd_on_done && (c == ce - 1);
            end else begin
                rx_a = bits[c / k];
                if_a.read = rd_on_done && (c == ce - 1);
            end
            tick(1);
            if (c + 1 == ce - 1) pre  = sel ? if_b.rxrdy : if_a.rxrdy;
            if (c + 1 == ce)     post = sel ? if_b.rxrdy : if_a.rxrdy;
        end
        if (sel) if_b.read = 1'b0; else if_a.read = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pre, post;
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        if_a.read = 1'b0; if_b.read = 1'b0;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        baud_a = 4'd0; baud_b = 4'd8;
        tick(3);
        chk("reset.data",  if_a.rx_data, 8'h00);
        chk("reset.rxrdy", if_a.rxrdy, 1'b0);
        chk("reset.perr",  if_a.perr, 1'b0);
        chk("reset.ferr",  if_a.ferr, 1'b0);
        chk("reset.ovf",   if_a.ovf, 1'b0);
        rst_n = 1'b1;
        tick(5);

        // 8N1 0xA5, then read
        push(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(0, 16, 8, 8'hA5, 0, 0, 1'b0, 1'b1, 0, 0, pre, post);
        chk("a5.rxrdy_before", pre, 1'b0);
        chk("a5.rxrdy_after", post, 1'b1);
        pop_check(0, "a5");
        read_pulse(0);
        chk("a5_read.rxrdy", if_a.rxrdy, 1'b0);
        chk("a5_read.data", if_a.rx_data, 8'hA5);

        // 7 data bits, even parity: 0x41 wants parity 0
        eight = 1'b0; pen = 1'b1; ohel = 1'b0;
        push(8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(0, 16, 8, 8'h41, 1, 1, 1'b1, 1'b1, 0, 0, pre, post);
        pop_check(0, "par_bad");
        read_pulse(0);
        push(8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(0, 16, 8, 8'h41, 1, 1, 1'b0, 1'b1, 0, 0, pre, post);
        pop_check(0, "par_ok");
        read_pulse(0);

        // framing error, then break held low
        eight = 1'b1; pen = 1'b0;
        push(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(0, 16, 8, 8'h3C, 0, 0, 1'b0, 1'b0, 0, 0, pre, post);
        pop_check(0, "ferr");
        read_pulse(0);
        tick(300);
        chk("break_low.rxrdy", if_a.rxrdy, 1'b0);
        rx_a = 1'b1;
        tick(40);
        chk("break_high.rxrdy", if_a.rxrdy, 1'b0);

        // glitch shorter than half a bit
        rx_a = 1'b0;
        tick(4);
        rx_a = 1'b1;
        tick(50);
        chk("glitch.rxrdy", if_a.rxrdy, 1'b0);
        chk("glitch.ferr", if_a.ferr, 1'b0);
        chk("glitch.perr", if_a.perr, 1'b0);

        // overrun, then read coinciding with completion
        push(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(0, 16, 8, 8'h11, 0, 0, 1'b0, 1'b1, 0, 0, pre, post);
        pop_check(0, "ovr1");
        push(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(0, 16, 8, 8'h22, 0, 0, 1'b0, 1'b1, 0, 0, pre, post);
        pop_check(0, "ovr2");
        push(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(0, 16, 8, 8'h33, 0, 0, 1'b0, 1'b1, 1, 0, pre, post);
        pop_check(0, "rd_on_done");

        // reset mid-frame; line held low through release
        send_frame(0, 16, 8, 8'hFF, 0, 0, 1'b0, 1'b1, 0, 80, pre, post);
        rst_n = 1'b0;
        #1;
        chk("midrst.data",  if_a.rx_data, 8'h00);
        chk("midrst.rxrdy", if_a.rxrdy, 1'b0);
        chk("midrst.ovf",   if_a.ovf, 1'b0);
        rx_a = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(250);
        chk("low_at_release.rxrdy", if_a.rxrdy, 1'b0);
        rx_a = 1'b1;
        tick(20);
        push(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(0, 16, 8, 8'h5A, 0, 0, 1'b0, 1'b1, 0, 0, pre, post);
        pop_check(0, "after_rst");

        // table bit time 868 clocks
        push(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(1, 868, 434, 8'h55, 0, 0, 1'b0, 1'b1, 0, 0, pre, post);
        chk("baud8.rxrdy_before", pre, 1'b0);
        chk("baud8.rxrdy_after", post, 1'b1);
        pop_check(1, "baud8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
